// File: rtl/rv32_types.sv
// Shared RV32 pipeline types: instruction word, bypass selects, decode payload and bubble.
package rv32_types;

   localparam int unsigned INSTR_W = 32;

   typedef logic [INSTR_W-1:0] rv_instr_t;

   // addi x0, x0, 0
   localparam rv_instr_t RV_NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      NO_BYPASS        = 2'd0,
      BYPASS_EXEC_BUFF = 2'd1,
      BYPASS_MEM_BUFF  = 2'd2
   } bypass_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        register_wb;
      logic        mem_write;
      logic        mem_read;
   } decoded_instr_t;

   typedef struct packed {
      rv_instr_t      instr;
      decoded_instr_t decoded_instr;
   } decoded_buffer_data_t;

   // NOP with every decoded control field cleared, so it never writes anything back
   localparam decoded_buffer_data_t bubble = '{instr: RV_NOP_INSTR, decoded_instr: '0};

endpackage

// File: rtl/rv32_bypass_mux.sv
// 3:1 operand select between register-file data and the two forwarding sources.
module rv32_bypass_mux
   import rv32_types::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  bypass_t           sel,
   input  logic [XLEN-1:0]   rf_data,
   input  logic [XLEN-1:0]   exec_result,
   input  logic [XLEN-1:0]   mem_result,
   output logic [XLEN-1:0]   operand_c
);

   // pick the operand source named by the stored select
   always_comb begin
      operand_c = rf_data;
      case (sel)
         BYPASS_EXEC_BUFF: operand_c = exec_result;
         BYPASS_MEM_BUFF:  operand_c = mem_result;
         default:          operand_c = rf_data;
      endcase
   end

endmodule

// File: rtl/rv32_decode_exec_buffer.sv
// Decode/execute pipeline register with bubble insertion, hold freeze and operand bypass.
module rv32_decode_exec_buffer
   import rv32_types::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 dec_valid,
   input  decoded_buffer_data_t dec_data,
   input  logic [XLEN-1:0]      dec_rs_data [2],
   input  bypass_t              dec_bypass_rs [2],
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 hold,
   input  logic [XLEN-1:0]      exec_buff_result,
   input  logic [XLEN-1:0]      mem_buff_result,
   output decoded_buffer_data_t decoded_buff,
   output logic                 buff_valid,
   output logic [XLEN-1:0]      exec_rs_data [2],
   output logic                 decode_ready,
   output logic [CNT_W-1:0]     stall_count,
   output logic [CNT_W-1:0]     flush_count
);

   bypass_t         sel_q  [2];
   logic [XLEN-1:0] rs_q   [2];

   // decode may only advance when nothing freezes or squashes it
   assign decode_ready = !hold && !stall && !flush;

   // capture priority: hold > flush > stall > valid instruction > idle bubble
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         decoded_buff <= bubble;
         buff_valid   <= 1'b0;
         stall_count  <= '0;
         flush_count  <= '0;
         for (int i = 0; i < 2; i++) begin
            sel_q[i] <= NO_BYPASS;
            rs_q[i]  <= '0;
         end
      end else if (hold) begin
         decoded_buff <= decoded_buff;
      end else if (flush || stall || !dec_valid) begin
         decoded_buff <= bubble;
         buff_valid   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            sel_q[i] <= NO_BYPASS;
            rs_q[i]  <= '0;
         end
         if (flush)
            flush_count <= flush_count + CNT_W'(1);
         else if (stall)
            stall_count <= stall_count + CNT_W'(1);
      end else begin
         decoded_buff <= dec_data;
         buff_valid   <= 1'b1;
         for (int i = 0; i < 2; i++) begin
            sel_q[i] <= dec_bypass_rs[i];
            rs_q[i]  <= dec_rs_data[i];
         end
      end
   end

   // one operand resolver per source register
   for (genvar g = 0; g < 2; g++) begin : g_bypass
      rv32_bypass_mux #(.XLEN(XLEN)) u_mux (
         .sel         (sel_q[g]),
         .rf_data     (rs_q[g]),
         .exec_result (exec_buff_result),
         .mem_result  (mem_buff_result),
         .operand_c   (exec_rs_data[g])
      );
   end

endmodule

// File: tb/tb_rv32_decode_exec_buffer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_rv32_decode_exec_buffer;
   import rv32_types::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 32;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 dec_valid;
   decoded_buffer_data_t dec_data;
   logic [XLEN-1:0]      dec_rs_data [2];
   bypass_t              dec_bypass_rs [2];
   logic                 stall;
   logic                 flush;
   logic                 hold;
   logic [XLEN-1:0]      exec_buff_result;
   logic [XLEN-1:0]      mem_buff_result;
   decoded_buffer_data_t decoded_buff;
   logic                 buff_valid;
   logic [XLEN-1:0]      exec_rs_data [2];
   logic                 decode_ready;
   logic [CNT_W-1:0]     stall_count;
   logic [CNT_W-1:0]     flush_count;

   int checks   = 0;
   int failures = 0;

   // reference model state
   decoded_buffer_data_t m_buff;
   logic                 m_valid;
   bypass_t              m_sel [2];
   logic [XLEN-1:0]      m_rs  [2];
   logic [CNT_W-1:0]     m_stall_cnt;
   logic [CNT_W-1:0]     m_flush_cnt;

   rv32_decode_exec_buffer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk              (clk),
      .resetn           (resetn),
      .dec_valid        (dec_valid),
      .dec_data         (dec_data),
      .dec_rs_data      (dec_rs_data),
      .dec_bypass_rs    (dec_bypass_rs),
      .stall            (stall),
      .flush            (flush),
      .hold             (hold),
      .exec_buff_result (exec_buff_result),
      .mem_buff_result  (mem_buff_result),
      .decoded_buff     (decoded_buff),
      .buff_valid       (buff_valid),
      .exec_rs_data     (exec_rs_data),
      .decode_ready     (decode_ready),
      .stall_count      (stall_count),
      .flush_count      (flush_count)
   );

   always #5 clk = ~clk;

   function automatic decoded_buffer_data_t mk(input logic [31:0] instr, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [31:0] imm, input logic wb,
                                               input logic mw, input logic mr);
      decoded_buffer_data_t d;
      d.instr                     = instr;
      d.decoded_instr.rd          = rd;
      d.decoded_instr.rs1         = rs1;
      d.decoded_instr.rs2         = rs2;
      d.decoded_instr.imm         = imm;
      d.decoded_instr.alu_op      = 4'd0;
      d.decoded_instr.register_wb = wb;
      d.decoded_instr.mem_write   = mw;
      d.decoded_instr.mem_read    = mr;
      return d;
   endfunction

   function automatic decoded_buffer_data_t rand_dec();
      decoded_buffer_data_t d;
      d.instr                     = $urandom;
      d.decoded_instr.rd          = 5'($urandom);
      d.decoded_instr.rs1         = 5'($urandom);
      d.decoded_instr.rs2         = 5'($urandom);
      d.decoded_instr.imm         = $urandom;
      d.decoded_instr.alu_op      = 4'($urandom);
      d.decoded_instr.register_wb = 1'($urandom);
      d.decoded_instr.mem_write   = 1'($urandom);
      d.decoded_instr.mem_read    = 1'($urandom);
      return d;
   endfunction

   function automatic bypass_t rand_sel();
      return bypass_t'(2'($urandom_range(0, 2)));
   endfunction

   // value execute should see for an operand given where it was forwarded from
   function automatic logic [XLEN-1:0] resolve(input bypass_t s, input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] ex, input logic [XLEN-1:0] mem);
      if (s == BYPASS_EXEC_BUFF) return ex;
      if (s == BYPASS_MEM_BUFF)  return mem;
      return rf;
   endfunction

   task automatic model_reset();
      m_buff      = bubble;
      m_valid     = 1'b0;
      m_stall_cnt = '0;
      m_flush_cnt = '0;
      for (int i = 0; i < 2; i++) begin
         m_sel[i] = NO_BYPASS;
         m_rs[i]  = '0;
      end
   endtask

   task automatic model_bubble();
      m_buff  = bubble;
      m_valid = 1'b0;
      for (int i = 0; i < 2; i++) m_sel[i] = NO_BYPASS;
   endtask

   // advance the model by one rising edge using the inputs currently driven
   task automatic model_edge();
      if (hold) begin
         // frozen
      end else if (flush) begin
         model_bubble();
         m_flush_cnt = m_flush_cnt + 1;
      end else if (stall) begin
         model_bubble();
         m_stall_cnt = m_stall_cnt + 1;
      end else if (dec_valid) begin
         m_buff  = dec_data;
         m_valid = 1'b1;
         for (int i = 0; i < 2; i++) begin
            m_sel[i] = dec_bypass_rs[i];
            m_rs[i]  = dec_rs_data[i];
         end
      end else begin
         model_bubble();
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag);
      logic [XLEN-1:0] e;
      logic            rdy;
      rdy = !hold && !stall && !flush;
      checks++;
      assert (decoded_buff === m_buff) else begin
         failures++;
         $error("FAIL %s decoded_buff obs=%h exp=%h", tag, decoded_buff, m_buff);
      end
      checks++;
      assert (buff_valid === m_valid) else begin
         failures++;
         $error("FAIL %s buff_valid obs=%b exp=%b", tag, buff_valid, m_valid);
      end
      checks++;
      assert (stall_count === m_stall_cnt) else begin
         failures++;
         $error("FAIL %s stall_count obs=%0d exp=%0d", tag, stall_count, m_stall_cnt);
      end
      checks++;
      assert (flush_count === m_flush_cnt) else begin
         failures++;
         $error("FAIL %s flush_count obs=%0d exp=%0d", tag, flush_count, m_flush_cnt);
      end
      checks++;
      assert (decode_ready === rdy) else begin
         failures++;
         $error("FAIL %s decode_ready obs=%b exp=%b", tag, decode_ready, rdy);
      end
      if (m_valid) begin
         for (int i = 0; i < 2; i++) begin
            e = resolve(m_sel[i], m_rs[i], exec_buff_result, mem_buff_result);
            checks++;
            assert (exec_rs_data[i] === e) else begin
               failures++;
               $error("FAIL %s exec_rs_data[%0d] obs=%h exp=%h", tag, i, exec_rs_data[i], e);
            end
         end
      end
   endtask

   task automatic check_reset(input string tag);
      check(tag);
      for (int i = 0; i < 2; i++) begin
         checks++;
         assert (exec_rs_data[i] === '0) else begin
            failures++;
            $error("FAIL %s reset exec_rs_data[%0d] obs=%h exp=0", tag, i, exec_rs_data[i]);
         end
      end
   endtask

   task automatic drive(input logic v, input decoded_buffer_data_t d, input logic [XLEN-1:0] r0,
                        input logic [XLEN-1:0] r1, input bypass_t s0, input bypass_t s1);
      dec_valid        = v;
      dec_data         = d;
      dec_rs_data[0]   = r0;
      dec_rs_data[1]   = r1;
      dec_bypass_rs[0] = s0;
      dec_bypass_rs[1] = s1;
   endtask

   initial begin
      resetn           = 1'b0;
      stall            = 1'b0;
      flush            = 1'b0;
      hold             = 1'b0;
      exec_buff_result = 32'h1111_1111;
      mem_buff_result  = 32'h2222_2222;
      drive(1'b1, rand_dec(), $urandom, $urandom, BYPASS_EXEC_BUFF, BYPASS_MEM_BUFF);
      model_reset();

      // reset held across an edge: outputs at reset values
      #12;
      check_reset("reset");
      hold = 1'b1;
      #1;
      check("reset_hold_ready");
      hold = 1'b0;
      resetn = 1'b1;

      // ALU chain: addi x1,x0,5 then add x2,x1,x1 forwarded from the exec buffer
      drive(1'b1, mk(32'h0050_0093, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 1'b0, 1'b0),
            32'd0, 32'd0, NO_BYPASS, NO_BYPASS);
      tick();
      check("addi");
      drive(1'b1, mk(32'h0010_8133, 5'd2, 5'd1, 5'd1, 32'd0, 1'b1, 1'b0, 1'b0),
            32'hBAD0_0001, 32'hBAD0_0002, BYPASS_EXEC_BUFF, BYPASS_EXEC_BUFF);
      tick();
      exec_buff_result = 32'd5;
      #1;
      check("alu_chain");

      // load-use: lw x3 then add x4,x3,x0 stalled one cycle, then forwarded from mem buffer
      drive(1'b1, mk(32'h0000_2183, 5'd3, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1),
            32'd0, 32'd0, NO_BYPASS, NO_BYPASS);
      tick();
      check("lw");
      drive(1'b1, mk(32'h0001_8233, 5'd4, 5'd3, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0),
            32'h0BAD_BAD0, 32'd0, NO_BYPASS, NO_BYPASS);
      stall = 1'b1;
      #1;
      check("lu_pre");
      tick();
      check("lu_bubble");
      stall = 1'b0;
      dec_bypass_rs[0] = BYPASS_MEM_BUFF;
      tick();
      mem_buff_result = 32'hDEAD_BEEF;
      #1;
      check("lu_add");

      // flush with simultaneous stall: counted only as a flush
      drive(1'b1, rand_dec(), $urandom, $urandom, rand_sel(), rand_sel());
      flush = 1'b1;
      stall = 1'b1;
      #1;
      check("fs_pre");
      tick();
      check("flush_stall");
      flush = 1'b0;
      stall = 1'b0;

      // hold for three cycles with toggling decode inputs, then capture on the 4th edge
      drive(1'b1, rand_dec(), $urandom, $urandom, rand_sel(), rand_sel());
      tick();
      check("pre_hold");
      hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, rand_dec(), $urandom, $urandom, rand_sel(), rand_sel());
         stall = 1'($urandom);
         tick();
         check("hold");
      end
      hold  = 1'b0;
      stall = 1'b0;
      drive(1'b1, rand_dec(), $urandom, $urandom, rand_sel(), rand_sel());
      tick();
      check("post_hold");

      // flush raised during hold only acts once hold drops
      hold  = 1'b1;
      flush = 1'b1;
      tick();
      check("hold_flush");
      hold = 1'b0;
      tick();
      check("flush_after_hold");
      flush = 1'b0;

      // NO_BYPASS on x0 ignores the forwarding sources
      drive(1'b1, mk(32'h0000_0033, 5'd5, 5'd0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0),
            32'd0, 32'd0, NO_BYPASS, NO_BYPASS);
      tick();
      for (int c = 0; c < 3; c++) begin
         exec_buff_result = $urandom;
         mem_buff_result  = $urandom;
         #1;
         check("x0_nobypass");
      end

      // randomized traffic
      for (int c = 0; c < 300; c++) begin
         drive(($urandom_range(0, 3) != 0), rand_dec(), $urandom, $urandom, rand_sel(), rand_sel());
         hold             = ($urandom_range(0, 3) == 0);
         flush            = ($urandom_range(0, 9) == 0);
         stall            = ($urandom_range(0, 6) == 0);
         exec_buff_result = $urandom;
         mem_buff_result  = $urandom;
         #1;
         check("rand_pre");
         tick();
         check("rand");
      end

      // asynchronous reset pulse between edges while holding a valid instruction
      hold  = 1'b0;
      flush = 1'b0;
      stall = 1'b0;
      drive(1'b1, rand_dec(), $urandom, $urandom, NO_BYPASS, BYPASS_EXEC_BUFF);
      tick();
      check("pre_rst_pulse");
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      check_reset("rst_pulse");
      #1;
      resetn = 1'b1;
      drive(1'b1, rand_dec(), $urandom, $urandom, BYPASS_MEM_BUFF, NO_BYPASS);
      tick();
      check("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
